// File: rtl/even_pipe_issue_scheduler_pkg.sv
// Shared types and default latencies for the even-pipe issue scheduler.
package spu_sched_pkg;

    localparam int MAX_LAT_DEF  = 8;
    localparam int LAT_FX1_DEF  = 2;
    localparam int LAT_FX2_DEF  = 4;
    localparam int LAT_BYTE_DEF = 4;
    localparam int LAT_SP_DEF   = 6;
    localparam int ADDR_W       = 7;

    typedef enum logic [1:0] {
        UNIT_FX1  = 2'd0,
        UNIT_FX2  = 2'd1,
        UNIT_BYTE = 2'd2,
        UNIT_SP   = 2'd3
    } unit_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rt;
    } slot_t;

    // Issue-to-writeback distance of a unit; callers may override the defaults.
    function automatic int unit_latency(
        unit_e unit,
        int    lat_fx1  = LAT_FX1_DEF,
        int    lat_fx2  = LAT_FX2_DEF,
        int    lat_byte = LAT_BYTE_DEF,
        int    lat_sp   = LAT_SP_DEF
    );
        int lat;
        lat = lat_fx1;
        case (unit)
            UNIT_FX1:  lat = lat_fx1;
            UNIT_FX2:  lat = lat_fx2;
            UNIT_BYTE: lat = lat_byte;
            UNIT_SP:   lat = lat_sp;
            default:   lat = lat_fx1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/even_pipe_issue_scheduler_slot_match.sv
// Compares one reservation slot against the decoded sources and destination.
module sched_slot_match
    import spu_sched_pkg::*;
(
    input  slot_t             slot,
    input  logic [2:0]        src_used,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] rc_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              src_hit,
    output logic              rt_hit
);

    // src_used is ordered {ra, rb, rc}.
    assign src_hit = slot.valid & ((src_used[2] & (ra_addr == slot.rt)) |
                                   (src_used[1] & (rb_addr == slot.rt)) |
                                   (src_used[0] & (rc_addr == slot.rt)));
    assign rt_hit  = slot.valid & (rt_addr == slot.rt);

endmodule

// File: rtl/even_pipe_issue_scheduler.sv
// Even-pipe issue gate with a writeback reservation shift register.
// Define SCHED_FWD_EN when the RF/FWD stage forwards the WB bus (RAW ignores slot[0]).
module even_pipe_issue_scheduler
    import spu_sched_pkg::*;
#(
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int LAT_FX1  = LAT_FX1_DEF,
    parameter int LAT_FX2  = LAT_FX2_DEF,
    parameter int LAT_BYTE = LAT_BYTE_DEF,
    parameter int LAT_SP   = LAT_SP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        in_unit,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic [2:0]        in_src_used,
    input  logic [ADDR_W-1:0] in_ra_addr,
    input  logic [ADDR_W-1:0] in_rb_addr,
    input  logic [ADDR_W-1:0] in_rc_addr,
    output logic              in_ready,
    output logic [3:0]        issue_en,
    output logic              wb_exp_valid,
    output logic [ADDR_W-1:0] wb_exp_addr,
    output logic [3:0]        inflight_cnt
);

`ifdef SCHED_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    slot_t [MAX_LAT-1:0] slot_q;
    slot_t [MAX_LAT-1:0] slot_d;
    logic  [MAX_LAT-1:0] src_hit;
    logic  [MAX_LAT-1:0] rt_hit;
    logic  [3:0]         cnt_q;
    logic  [3:0]         cnt_d;
    logic                struct_haz;
    logic                raw_haz;
    logic                waw_haz;
    logic                fire;
    int                  lat;

    for (genvar g = 0; g < MAX_LAT; g++) begin : g_match
        sched_slot_match u_match (
            .slot     (slot_q[g]),
            .src_used (in_src_used),
            .ra_addr  (in_ra_addr),
            .rb_addr  (in_rb_addr),
            .rc_addr  (in_rc_addr),
            .rt_addr  (in_rt_addr),
            .src_hit  (src_hit[g]),
            .rt_hit   (rt_hit[g])
        );
    end

    // A new result lands in slot[lat-1] while slot[k] moves to slot[k-1]:
    // k == lat collides on the WB port, k > lat would retire after the younger write.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        lat        = unit_latency(unit_e'(in_unit), LAT_FX1, LAT_FX2, LAT_BYTE, LAT_SP);
        struct_haz = 1'b0;
        raw_haz    = 1'b0;
        waw_haz    = 1'b0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (src_hit[k] && (k > 0 || !FWD))
                raw_haz = 1'b1;
            if (in_reg_write && slot_q[k].valid && k == lat)
                struct_haz = 1'b1;
            if (in_reg_write && rt_hit[k] && k >= lat)
                waw_haz = 1'b1;
        end
    end

    assign in_ready = !reset && !(struct_haz || raw_haz || waw_haz);
    assign fire     = in_valid && in_ready;
    assign issue_en = fire ? (4'b0001 << in_unit) : 4'b0000;

    always_comb begin
        for (int k = 0; k < MAX_LAT - 1; k++)
            slot_d[k] = slot_q[k+1];
        slot_d[MAX_LAT-1] = '0;
        if (fire && in_reg_write) begin
            for (int k = 0; k < MAX_LAT; k++)
                if (k == lat - 1)
                    slot_d[k] = '{valid: 1'b1, rt: in_rt_addr};
        end
        cnt_d = 4'd0;
        for (int k = 0; k < MAX_LAT; k++)
            cnt_d = cnt_d + 4'(slot_d[k].valid);
    end

    // NOTE: the slot array is reset in full; stale rt bits would otherwise show on wb_exp_addr.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every slot shifts from pre-edge values.
        if (reset) begin
            slot_q <= '0;
            cnt_q  <= 4'd0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wb_exp_valid = slot_q[0].valid;
    assign wb_exp_addr  = slot_q[0].rt;
    assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_even_pipe_issue_scheduler.sv
// Self-checking bench: vector table plus hand-written hazard sequences, WB scoreboard.
module tb_even_pipe_issue_scheduler;
    import spu_sched_pkg::*;

`ifdef SCHED_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_unit;
    logic       in_reg_write;
    logic [6:0] in_rt_addr;
    logic [2:0] in_src_used;
    logic [6:0] in_ra_addr, in_rb_addr, in_rc_addr;
    logic       in_ready;
    logic [3:0] issue_en;
    logic       wb_exp_valid;
    logic [6:0] wb_exp_addr;
    logic [3:0] inflight_cnt;

    even_pipe_issue_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_unit      (in_unit),
        .in_reg_write (in_reg_write),
        .in_rt_addr   (in_rt_addr),
        .in_src_used  (in_src_used),
        .in_ra_addr   (in_ra_addr),
        .in_rb_addr   (in_rb_addr),
        .in_rc_addr   (in_rc_addr),
        .in_ready     (in_ready),
        .issue_en     (issue_en),
        .wb_exp_valid (wb_exp_valid),
        .wb_exp_addr  (wb_exp_addr),
        .inflight_cnt (inflight_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        unit_e      unit;
        logic       rw;
        logic [6:0] rt;
        logic [2:0] su;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic       rdy;
    } vec_t;

    typedef struct {
        int         due;
        logic [6:0] rt;
    } wb_t;

    wb_t  sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic int model_lat(unit_e u);
        case (u)
            UNIT_FX1:  return 2;
            UNIT_FX2:  return 4;
            UNIT_BYTE: return 4;
            default:   return 6;
        endcase
    endfunction

    function automatic vec_t mk(logic rst, logic valid, unit_e u, logic rw, logic [6:0] rt,
                                logic [2:0] su, logic [6:0] ra, logic [6:0] rb,
                                logic [6:0] rc, logic rdy);
        vec_t v;
        v.rst = rst; v.valid = valid; v.unit = u; v.rw = rw; v.rt = rt;
        v.su = su; v.ra = ra; v.rb = rb; v.rc = rc; v.rdy = rdy;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, 1'b0, UNIT_FX1, 1'b0, 7'd0, 3'b000, 7'd0, 7'd0, 7'd0, 1'b1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // One cycle: drive, compare at the falling edge, then advance past the rising edge.
    task automatic step(input vec_t v, input string name);
        int         idx;
        logic [3:0] exp_en;
        reset        = v.rst;
        in_valid     = v.valid;
        in_unit      = v.unit;
        in_reg_write = v.rw;
        in_rt_addr   = v.rt;
        in_src_used  = v.su;
        in_ra_addr   = v.ra;
        in_rb_addr   = v.rb;
        in_rc_addr   = v.rc;
        @(negedge clk);
        exp_en = (v.valid && v.rdy) ? (4'b0001 << v.unit) : 4'b0000;
        check({name, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
        check({name, ".issue_en"}, 32'(issue_en), 32'(exp_en));
        check({name, ".inflight_cnt"}, 32'(inflight_cnt), 32'(sb.size()));
        idx = -1;
        foreach (sb[i]) if (sb[i].due == cyc) idx = i;
        if (idx >= 0) begin
            check({name, ".wb_exp_valid"}, 32'(wb_exp_valid), 32'd1);
            check({name, ".wb_exp_addr"}, 32'(wb_exp_addr), 32'(sb[idx].rt));
            sb.delete(idx);
        end else begin
            check({name, ".wb_exp_valid"}, 32'(wb_exp_valid), 32'd0);
        end
        if (v.valid && v.rdy && v.rw)
            sb.push_back('{due: cyc + model_lat(v.unit), rt: v.rt});
        @(posedge clk);
        #1;
        if (v.rst) sb.delete();
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(idle(), "drain");
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_unit = 2'd0; in_reg_write = 1'b1;
        in_rt_addr = 7'd1; in_src_used = 3'b000;
        in_ra_addr = 7'd0; in_rb_addr = 7'd0; in_rc_addr = 7'd0;
        @(posedge clk);
        #1;

        // Reset held with a valid instruction presented.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, UNIT_FX1, 1, 7'd1, 3'b000, 0, 0, 0, 0));
        // FX2 rt=3: WB four cycles later, count 1 through the WB cycle.
        tbl.push_back(mk(0, 1, UNIT_FX2, 1, 7'd3, 3'b000, 0, 0, 0, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(idle());
        // Register 0 is tracked like any other; RAW on rb, rc, ra.
        tbl.push_back(mk(0, 1, UNIT_BYTE, 1, 7'd0, 3'b000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, UNIT_FX1, 0, 7'd0, 3'b010, 7'd9, 7'd0, 7'd9, 0));
        tbl.push_back(mk(0, 1, UNIT_FX1, 0, 7'd0, 3'b001, 7'd9, 7'd9, 7'd0, 0));
        tbl.push_back(mk(0, 1, UNIT_FX1, 0, 7'd0, 3'b100, 7'd0, 7'd9, 7'd9, 0));
        tbl.push_back(mk(0, 1, UNIT_FX1, 0, 7'd0, 3'b100, 7'd0, 7'd9, 7'd9, FWD));
        tbl.push_back(mk(0, 1, UNIT_FX1, 0, 7'd0, 3'b100, 7'd0, 7'd9, 7'd9, 1));
        // No reservation without reg_write, so a later writer of the same rt is free.
        tbl.push_back(mk(0, 1, UNIT_SP, 0, 7'd50, 3'b000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, UNIT_FX1, 1, 7'd50, 3'b000, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(idle());
        // WB port collision: SP then FX1 targeting the same WB cycle.
        tbl.push_back(mk(0, 1, UNIT_SP, 1, 7'd5, 3'b000, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(idle());
        tbl.push_back(mk(0, 1, UNIT_FX1, 1, 7'd6, 3'b000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, UNIT_FX1, 1, 7'd6, 3'b000, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(idle());

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // RAW back-to-back: consumer fires one cycle earlier with forwarding.
        step(mk(0, 1, UNIT_FX2, 1, 7'd3, 3'b000, 0, 0, 0, 1), "raw_prod");
        for (int i = 1; i <= 5; i++) begin
            logic exp;
            exp = FWD ? (i >= 4) : (i >= 5);
            step(mk(0, 1, UNIT_FX1, 1, 7'd7, 3'b100, 7'd3, 0, 0, exp), $sformatf("raw_cons%0d", i));
            if (exp) break;
        end
        drain(7);

        // WAW: the younger FX1 must not retire before the older SP.
        step(mk(0, 1, UNIT_SP, 1, 7'd9, 3'b000, 0, 0, 0, 1), "waw_sp");
        for (int i = 1; i <= 5; i++)
            step(mk(0, 1, UNIT_FX1, 1, 7'd9, 3'b000, 0, 0, 0, i == 5), $sformatf("waw_fx1_%0d", i));
        drain(7);

        // Reset mid-flight discards the reservation.
        step(mk(0, 1, UNIT_FX2, 1, 7'd4, 3'b000, 0, 0, 0, 1), "rst_issue");
        step(idle(), "rst_gap");
        step(mk(1, 0, UNIT_FX1, 0, 7'd0, 3'b000, 0, 0, 0, 0), "rst_pulse");
        drain(6);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
